jt900h_flags: RTL and testbench

- Flag-register stage directly downstream of the ALU.
- Latches the ALU's n/z/p/c/v/h outputs into the architectural F register, with per-flag update control from the decoder.
- Keeps the shadow F' register for EX F,F'.
- Evaluates the 4-bit condition code for jumps/calls/returns.
- Feeds the current N/H/C/Z back to the ALU as nin/hin/cin/zin, closing the DAA/ADC/SBC loop.

---
 rtl/jt900h_flags_pkg.sv | 54 +++++
 rtl/jt900h_cc.sv | 35 +++
 rtl/jt900h_flags.sv | 111 +++++++++++
 tb/tb_jt900h_flags.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/jt900h_flags_pkg.sv
// Shared constants for the TLCS-900H flag stage: flag-control codes,
// condition-code names, F bit positions and the per-flag update helper.
package jt900h_flags_pkg;

  typedef enum logic [1:0] {
    FKEEP = 2'd0,
    FALU  = 2'd1,
    FCLR  = 2'd2,
    FSET  = 2'd3
  } flag_ctl_e;

  typedef enum logic [3:0] {
    CC_F   = 4'd0,
    CC_LT  = 4'd1,
    CC_LE  = 4'd2,
    CC_ULE = 4'd3,
    CC_OV  = 4'd4,
    CC_MI  = 4'd5,
    CC_Z   = 4'd6,
    CC_C   = 4'd7,
    CC_T   = 4'd8,
    CC_GE  = 4'd9,
    CC_GT  = 4'd10,
    CC_UGT = 4'd11,
    CC_NOV = 4'd12,
    CC_PL  = 4'd13,
    CC_NZ  = 4'd14,
    CC_NC  = 4'd15
  } cc_e;

  localparam int FS_B = 7;
  localparam int FZ_B = 6;
  localparam int FH_B = 4;
  localparam int FV_B = 2;
  localparam int FN_B = 1;
  localparam int FC_B = 0;

  // Bits 5 and 3 of F read as zero
  localparam logic [7:0] F_MASK = 8'hD7;

  function automatic logic flag_upd(input logic cur, input logic [1:0] ctl,
                                    input logic alu);
    logic r;
    case (ctl)
      FKEEP:   r = cur;
      FALU:    r = alu;
      FCLR:    r = 1'b0;
      FSET:    r = 1'b1;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt900h_cc.sv
// Condition-code evaluator: combinational f/cc -> cc_ok. Codes 8..15 are
// the complements of 0..7. Also used by the DJNZ/conditional-return sequencer.
module jt900h_cc
  import jt900h_flags_pkg::*;
(
  input  logic [7:0] f,
  input  logic [3:0] cc,
  output logic       cc_ok
);

  logic s, z, v, c, base;

  assign s = f[FS_B];
  assign z = f[FZ_B];
  assign v = f[FV_B];
  assign c = f[FC_B];

  always_comb begin
    base = 1'b0;
    case (cc[2:0])
      3'd0: base = 1'b0;
      3'd1: base = s ^ v;
      3'd2: base = (s ^ v) | z;
      3'd3: base = c | z;
      3'd4: base = v;
      3'd5: base = s;
      3'd6: base = z;
      3'd7: base = c;
      default: base = 1'b0;
    endcase
  end

  assign cc_ok = base ^ cc[3];

endmodule

// File: rtl/jt900h_flags.sv
// F register stage after the ALU: per-flag updates, F load, F/F' swap and
// condition evaluation. Define JT900H_FLAGS_SHADOW_EN to build the F' register.
module jt900h_flags
  import jt900h_flags_pkg::*;
#(
  parameter logic [7:0] FRST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_p,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_h,
  input  logic [1:0] s_ctl,
  input  logic [1:0] z_ctl,
  input  logic [1:0] h_ctl,
  input  logic [1:0] v_ctl,
  input  logic [1:0] n_ctl,
  input  logic [1:0] c_ctl,
  input  logic       pv_sel,
  input  logic       ccf,
  input  logic       ld_f,
  input  logic [7:0] f_din,
  input  logic       ex_ff,
  input  logic [3:0] cc,
  output logic [7:0] f,
  output logic [7:0] falt,
  output logic       nin,
  output logic       hin,
  output logic       cin,
  output logic       zin,
  output logic       cc_ok
);

  logic [7:0] f_q, f_d;
  logic [7:0] upd;
  logic       c_new;

  // Flag-by-flag result when neither load nor swap is requested
  always_comb begin
    upd          = f_q;
    upd[FS_B]    = flag_upd(f_q[FS_B], s_ctl, alu_n);
    upd[FZ_B]    = flag_upd(f_q[FZ_B], z_ctl, alu_z);
    upd[FH_B]    = flag_upd(f_q[FH_B], h_ctl, alu_h);
    upd[FV_B]    = flag_upd(f_q[FV_B], v_ctl, pv_sel ? alu_p : alu_v);
    // N has no ALU source; passing its own value makes FALU act as KEEP
    upd[FN_B]    = flag_upd(f_q[FN_B], n_ctl, f_q[FN_B]);
    c_new        = flag_upd(f_q[FC_B], c_ctl, alu_c);
    upd[FC_B]    = ccf ? ~c_new : c_new;
    upd          = upd & F_MASK;
  end

`ifdef JT900H_FLAGS_SHADOW_EN
  logic [7:0] falt_q, falt_d;

  always_comb begin
    f_d    = f_q;
    falt_d = falt_q;
    if (ld_f) begin
      f_d = f_din & F_MASK;
    end else if (ex_ff) begin
      f_d    = falt_q;
      falt_d = f_q;
    end else begin
      f_d = upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= FRST & F_MASK;
      falt_q <= FRST & F_MASK;
    end else if (cen) begin
      f_q    <= f_d;
      falt_q <= falt_d;
    end
  end

  assign falt = falt_q;
`else
  // Without F' a swap still blocks the per-flag update, keeping priority intact
  always_comb begin
    f_d = f_q;
    if (ld_f)       f_d = f_din & F_MASK;
    else if (!ex_ff) f_d = upd;
  end

  always_ff @(posedge clk) begin
    if (rst)      f_q <= FRST & F_MASK;
    else if (cen) f_q <= f_d;
  end

  assign falt = 8'h00;
`endif

  assign f   = f_q;
  assign nin = f_q[FN_B];
  assign hin = f_q[FH_B];
  assign cin = f_q[FC_B];
  assign zin = f_q[FZ_B];

  jt900h_cc u_cc (
    .f     (f_q),
    .cc    (cc),
    .cc_ok (cc_ok)
  );

endmodule

// File: tb/tb_jt900h_flags.sv
// Directed bench for jt900h_flags; expectations follow the
// JT900H_FLAGS_SHADOW_EN setting of the build.
module tb_jt900h_flags;
  import jt900h_flags_pkg::*;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic       alu_n, alu_z, alu_p, alu_c, alu_v, alu_h;
  logic [1:0] s_ctl, z_ctl, h_ctl, v_ctl, n_ctl, c_ctl;
  logic       pv_sel, ccf, ld_f, ex_ff;
  logic [7:0] f_din;
  logic [3:0] cc;
  logic [7:0] f, falt;
  logic       nin, hin, cin, zin, cc_ok;

  int tests = 0;
  int fails = 0;

  jt900h_flags #(.FRST(8'h00)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .alu_n(alu_n), .alu_z(alu_z), .alu_p(alu_p), .alu_c(alu_c),
    .alu_v(alu_v), .alu_h(alu_h),
    .s_ctl(s_ctl), .z_ctl(z_ctl), .h_ctl(h_ctl), .v_ctl(v_ctl),
    .n_ctl(n_ctl), .c_ctl(c_ctl),
    .pv_sel(pv_sel), .ccf(ccf), .ld_f(ld_f), .f_din(f_din), .ex_ff(ex_ff),
    .cc(cc), .f(f), .falt(falt),
    .nin(nin), .hin(hin), .cin(cin), .zin(zin), .cc_ok(cc_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; cen = 1;
    {alu_n, alu_z, alu_p, alu_c, alu_v, alu_h} = '0;
    s_ctl = FKEEP; z_ctl = FKEEP; h_ctl = FKEEP;
    v_ctl = FKEEP; n_ctl = FKEEP; c_ctl = FKEEP;
    pv_sel = 0; ccf = 0; ld_f = 0; ex_ff = 0; f_din = 8'h00; cc = 4'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // Reset with cen low
    rst = 1; cen = 0;
    step();
    idle();
    chk("rst_f", f, 8'h00);
    chk("rst_falt", falt, 8'h00);
    cc = CC_T;  #1 chk("rst_cc_T", {7'd0, cc_ok}, 8'd1);
    cc = CC_F;  #1 chk("rst_cc_F", {7'd0, cc_ok}, 8'd0);

    // ALU update, N forced set
    alu_n = 1; alu_z = 0; alu_h = 1; alu_v = 1; alu_c = 1;
    s_ctl = FALU; z_ctl = FALU; h_ctl = FALU; v_ctl = FALU; c_ctl = FALU;
    n_ctl = FSET;
    step();
    idle();
    chk("alu_f", f, 8'h97);
    chk("alu_cin", {7'd0, cin}, 8'd1);
    chk("alu_hin", {7'd0, hin}, 8'd1);
    cc = CC_LT;  #1 chk("cc_LT", {7'd0, cc_ok}, 8'd0);
    cc = CC_ULE; #1 chk("cc_ULE", {7'd0, cc_ok}, 8'd1);
    cc = CC_GE;  #1 chk("cc_GE", {7'd0, cc_ok}, 8'd1);

    // N ignores ALU code
    n_ctl = FALU;
    step();
    idle();
    chk("n_alu_keep", {7'd0, nin}, 8'd1);

    // Load wins over swap and z_ctl
    ld_f = 1; f_din = 8'hFF; ex_ff = 1; z_ctl = FCLR;
    step();
    idle();
    chk("ld_f", f, 8'hD7);
    chk("ld_falt", falt, 8'h00);
    cc = CC_NZ; #1 chk("cc_NZ", {7'd0, cc_ok}, 8'd0);

    // CCF
    ccf = 1;
    step();
    idle();
    chk("ccf_f", f, 8'hD6);
    chk("ccf_cin", {7'd0, cin}, 8'd0);

    // CCF after SET gives 0; V from parity
    ccf = 1; c_ctl = FSET; v_ctl = FALU; pv_sel = 1; alu_p = 0; alu_v = 1;
    step();
    idle();
    chk("ccf_set_pv", f, 8'hD2);

    // Build f=41, falt=10
    ld_f = 1; f_din = 8'h10;
    step();
    idle();
    ex_ff = 1;
    step();
    idle();
    ld_f = 1; f_din = 8'h41;
    step();
    idle();
    chk("pre_swap_f", f, 8'h41);

    ex_ff = 1; c_ctl = FCLR;
    step();
    idle();
`ifdef JT900H_FLAGS_SHADOW_EN
    chk("swap1_f", f, 8'h10);
    chk("swap1_falt", falt, 8'h41);
`else
    chk("swap1_f", f, 8'h41);
    chk("swap1_falt", falt, 8'h00);
`endif
    ex_ff = 1;
    step();
    idle();
`ifdef JT900H_FLAGS_SHADOW_EN
    chk("swap2_f", f, 8'h41);
    chk("swap2_falt", falt, 8'h10);
`else
    chk("swap2_f", f, 8'h41);
    chk("swap2_falt", falt, 8'h00);
`endif

    // cen gating
    c_ctl = FCLR;
    step();
    idle();
    chk("cen_clr", f, 8'h40);
    for (int i = 0; i < 3; i++) begin
      cen = 0; c_ctl = FSET;
      step();
      chk("cen_hold_f", f, 8'h40);
      chk("cen_hold_cin", {7'd0, cin}, 8'd0);
    end
    cen = 1; c_ctl = FSET;
    step();
    idle();
    chk("cen_set_f", f, 8'h41);
    chk("cen_set_cin", {7'd0, cin}, 8'd1);

    // Reset beats load
    rst = 1; ld_f = 1; f_din = 8'hFF;
    step();
    idle();
    chk("rst_mid_f", f, 8'h00);
    chk("rst_mid_falt", falt, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
